// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial adder/subtractor. A single 1-bit full-adder slice and a carry
// flip-flop process the operands one bit per clock, LSB first. Subtraction
// is done as a + ~b + 1: b is inverted when it is loaded, and the carry is
// preset to 1.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset, overrides everything else
//   start  - request pulse, accepted only in IDLE or DONE
//   sub    - 0 = add, 1 = subtract (sampled together with start)
//   a, b   - operands (sampled together with start)
//   busy   - high while bits are being processed (WIDTH cycles)
//   done   - one-cycle pulse when result and flags are valid
//   result - sum or difference, held until the next completion
//   cout   - add: carry out; sub: borrow (1 when a < b unsigned)
//   ovf    - signed overflow
//   zero   - result == 0
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One spare bit so the counter cannot wrap before WIDTH-1 is reached.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] s_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             sub_q_reg;
  logic             a_msb_reg;
  logic             bx_msb_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  // Operand B, conditionally inverted for subtraction.
  logic [WIDTH-1:0] bx;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign bx[gi] = b[gi] ^ sub;
    end
  endgenerate

  // The single full-adder slice working on the current LSBs.
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] s_sh_next;

  assign sum_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) |
                      (a_sh_reg[0] & carry_reg)   |
                      (b_sh_reg[0] & carry_reg);
  // Sum bits enter at the MSB, so after WIDTH steps the LSB has reached bit 0.
  assign s_sh_next  = {sum_bit, s_sh_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      s_sh_reg   <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
      sub_q_reg  <= 1'b0;
      a_msb_reg  <= 1'b0;
      bx_msb_reg <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        // DONE accepts a new request exactly like IDLE, so that operations
        // can run back to back without an idle cycle in between.
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= bx;
            s_sh_reg   <= '0;
            carry_reg  <= sub;
            sub_q_reg  <= sub;
            a_msb_reg  <= a[WIDTH-1];
            bx_msb_reg <= bx[WIDTH-1];
            count_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SHIFT;
          end else begin
            state_reg  <= IDLE;
          end
        end

        SHIFT: begin
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          s_sh_reg  <= s_sh_next;
          carry_reg <= carry_next;
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST) begin
            result_reg <= s_sh_next;
            // For subtraction a missing carry means a borrow.
            cout_reg   <= sub_q_reg ^ carry_next;
            // Overflow: both adder inputs share a sign that the sum does not.
            ovf_reg    <= (a_msb_reg == bx_msb_reg) && (sum_bit != a_msb_reg);
            zero_reg   <= (s_sh_next == '0);
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign cout   = cout_reg;
  assign ovf    = ovf_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=8). Expected values come from an
// arithmetic reference model working on whole integers.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  localparam logic         DS[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [W-1:0] DA[5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hFF};
  localparam logic [W-1:0] DB[5] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01};

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t   m;
    longint ux, uy, sx, sy, u, sg;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      u   = ux - uy;
      sg  = sx - sy;
      m.c = (ux < uy);
    end else begin
      u   = ux + uy;
      sg  = sx + sy;
      m.c = (u >= (longint'(1) << W));
    end
    m.r = u[W-1:0];
    m.v = (sg > ((longint'(1) << (W-1)) - 1)) || (sg < -(longint'(1) << (W-1)));
    m.z = (m.r == '0);
    return m;
  endfunction

  function automatic res_t observed();
    res_t o;
    o.r = result;
    o.c = cout;
    o.v = ovf;
    o.z = zero;
    return o;
  endfunction

  // Pulse start for one cycle; returns at the negedge of the first busy cycle
  // with the operand inputs scrambled.
  task automatic kick(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    sub   = 1'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Advance negedge by negedge until done is seen or the budget runs out.
  // n is the cycle number relative to the start edge.
  task automatic wait_done(input int n0, output int n, output int nbusy, output bit timeout);
    n       = n0;
    nbusy   = 0;
    timeout = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    // start asserted together with reset must be lost
    rst = 1'b1; start = 1'b1; sub = 1'b1; a = 8'h05; b = 8'h03;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, cout, ovf, zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b want all 0",
               busy, done, result, cout, ovf, zero);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_start_lost got busy=%b done=%b want 0 0", busy, done);
    end
    $display("test_reset: rst with start held, outputs cleared");
  endtask

  task automatic test_directed();
    int n, nb;
    bit to;
    res_t exp, got;
    for (int i = 0; i < 5; i++) begin
      kick(DS[i], DA[i], DB[i]);
      wait_done(1, n, nb, to);
      exp = model(DS[i], DA[i], DB[i]);
      got = observed();
      checks++;
      if (to !== 1'b0) begin
        errors++;
        $display("FAIL directed_timeout[%0d] got no done want done", i);
      end
      checks++;
      if (n != W + 1 || nb != W) begin
        errors++;
        $display("FAIL directed_latency[%0d] got done@%0d busy=%0d want done@%0d busy=%0d", i, n, nb, W + 1, W);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL directed_result[%0d] got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, got.r, got.c, got.v, got.z, exp.r, exp.c, exp.v, exp.z);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL directed_done_pulse[%0d] got busy=%b done=%b want 0 0", i, busy, done);
      end
      $display("test_directed: sub=%b a=%h b=%h -> r=%h c=%b v=%b z=%b",
               DS[i], DA[i], DB[i], got.r, got.c, got.v, got.z);
    end
  endtask

  task automatic test_random();
    int n, nb;
    bit to;
    res_t exp, got, prev;
    logic s;
    logic [W-1:0] x, y;
    prev = observed();
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      x = W'($urandom);
      y = (i % 4 == 0) ? x : W'($urandom);
      kick(s, x, y);
      repeat (3) @(negedge clk);
      // previous outputs must hold through the next operation
      got = observed();
      checks++;
      if (got !== prev) begin
        errors++;
        $display("FAIL random_hold[%0d] got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, got.r, got.c, got.v, got.z, prev.r, prev.c, prev.v, prev.z);
      end
      wait_done(4, n, nb, to);
      exp = model(s, x, y);
      got = observed();
      checks++;
      if (to !== 1'b0 || n != W + 1) begin
        errors++;
        $display("FAIL random_latency[%0d] got done@%0d timeout=%b want done@%0d", i, n, to, W + 1);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_result[%0d] got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, got.r, got.c, got.v, got.z, exp.r, exp.c, exp.v, exp.z);
      end
      prev = exp;
      $display("test_random[%0d]: sub=%b a=%h b=%h -> r=%h c=%b v=%b z=%b",
               i, s, x, y, got.r, got.c, got.v, got.z);
    end
  endtask

  task automatic test_ignore_start();
    int n, nb;
    bit to;
    res_t exp, got;
    kick(1'b1, 8'h05, 8'h03);
    repeat (2) @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h10;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, n, nb, to);
    exp = model(1'b1, 8'h05, 8'h03);
    got = observed();
    checks++;
    if (to !== 1'b0 || n != W + 1) begin
      errors++;
      $display("FAIL ignore_latency got done@%0d timeout=%b want done@%0d", n, to, W + 1);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ignore_result got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
               got.r, got.c, got.v, got.z, exp.r, exp.c, exp.v, exp.z);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_no_second_op got busy=%b done=%b want 0 0", busy, done);
    end
    $display("test_ignore_start: start during busy ignored, r=%h", got.r);
  endtask

  task automatic test_back_to_back();
    int n, nb;
    bit to;
    res_t exp, got;
    kick(1'b0, 8'h7F, 8'h01);
    wait_done(1, n, nb, to);
    exp = model(1'b0, 8'h7F, 8'h01);
    got = observed();
    checks++;
    if (to !== 1'b0 || got !== exp) begin
      errors++;
      $display("FAIL b2b_first got r=%h c=%b v=%b z=%b timeout=%b want r=%h c=%b v=%b z=%b",
               got.r, got.c, got.v, got.z, to, exp.r, exp.c, exp.v, exp.z);
    end
    // start while done is high
    start = 1'b1; sub = 1'b1; a = 8'h80; b = 8'h01;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_no_gap got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(1, n, nb, to);
    exp = model(1'b1, 8'h80, 8'h01);
    got = observed();
    checks++;
    if (to !== 1'b0 || n != W + 1 || nb != W) begin
      errors++;
      $display("FAIL b2b_latency got done@%0d busy=%0d timeout=%b want done@%0d busy=%0d", n, nb, to, W + 1, W);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_second got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
               got.r, got.c, got.v, got.z, exp.r, exp.c, exp.v, exp.z);
    end
    @(negedge clk);
    $display("test_back_to_back: second op r=%h v=%b", got.r, got.v);
  endtask

  task automatic test_reset_mid_op();
    int n, nb;
    bit to, seen;
    res_t exp, got;
    kick(1'b1, 8'h03, 8'h05);   // leaves non-zero result and cout=1
    wait_done(1, n, nb, to);
    @(negedge clk);
    kick(1'b1, 8'h05, 8'h03);
    repeat (4) @(negedge clk);  // now in the busy cycle with count = 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, result, cout, ovf, zero} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b want all 0",
               busy, done, result, cout, ovf, zero);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done got activity=%b want 0", seen);
    end
    kick(1'b1, 8'h05, 8'h03);
    wait_done(1, n, nb, to);
    exp = model(1'b1, 8'h05, 8'h03);
    got = observed();
    checks++;
    if (to !== 1'b0 || got !== exp) begin
      errors++;
      $display("FAIL midreset_fresh got r=%h c=%b v=%b z=%b timeout=%b want r=%h c=%b v=%b z=%b",
               got.r, got.c, got.v, got.z, to, exp.r, exp.c, exp.v, exp.z);
    end
    @(negedge clk);
    $display("test_reset_mid_op: aborted op, fresh op r=%h", got.r);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
